// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: captures the shown move, then each
// round replays the stored sequence as timed presses and appends a new
// pseudo-random move taken from an 8-bit LFSR.
module jogador_automatico #(
    parameter int          N_JOGADAS = 16,
    parameter int          T_PRESS   = 50,
    parameter int          T_GAP     = 50,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               iniciar,
    input  logic                               exibe,
    input  logic [3:0]                         leds,
    input  logic                               pronto,
    output logic [3:0]                         botoes,
    output logic                               jogando,
    output logic [$clog2(N_JOGADAS+1)-1:0]     db_tamanho,
    output logic [3:0]                         db_estado
);

    localparam int LW   = $clog2(N_JOGADAS + 1);
    localparam int AW   = (N_JOGADAS > 1) ? $clog2(N_JOGADAS) : 1;
    localparam int TMAX = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        OCIOSO         = 4'h0,
        LIMPA          = 4'h1,
        ESPERA_EXIBE   = 4'h2,
        ESPERA_FIM     = 4'h3,
        PAUSA          = 4'h4,
        APERTA         = 4'h5,
        SOLTA          = 4'h6,
        APERTA_NOVA    = 4'h7,
        SOLTA_NOVA     = 4'h8,
        ESPERA_PRONTO  = 4'h9,
        FIM            = 4'hA
    } estado_t;

    estado_t         state, nextState;
    logic [TW-1:0]   timer;
    logic [7:0]      lfsr;
    logic [3:0]      mem [N_JOGADAS];
    logic [LW-1:0]   len;
    logic [AW-1:0]   idx;

    logic            ledsOneHot, pressDone, gapDone, timed;
    logic [3:0]      newMove;

    assign ledsOneHot = (leds != 4'b0) && ((leds & (leds - 4'd1)) == 4'b0);
    assign pressDone  = (timer == TW'(T_PRESS - 1));
    assign gapDone    = (timer == TW'(T_GAP - 1));
    assign timed      = state inside {PAUSA, APERTA, SOLTA, APERTA_NOVA, SOLTA_NOVA};
    assign newMove    = 4'b0001 << lfsr[1:0];

    // LFSR free-runs from reset; a zero seed would lock up, so it becomes 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= (SEED == 8'h00) ? 8'h01 : SEED;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= OCIOSO;
        else       state <= nextState;
    end

    // Next-state logic; pronto aborts any active state into fim
    always_comb begin
        nextState = state;
        case (state)
            OCIOSO:        if (iniciar) nextState = LIMPA;
            LIMPA:         nextState = ESPERA_EXIBE;
            ESPERA_EXIBE:  if (exibe && ledsOneHot) nextState = ESPERA_FIM;
            ESPERA_FIM:    if (!exibe) nextState = PAUSA;
            PAUSA:         if (gapDone) nextState = APERTA;
            APERTA:        if (pressDone) nextState = SOLTA;
            SOLTA: begin
                if (gapDone) begin
                    if (LW'(idx) + LW'(1) < len)     nextState = APERTA;
                    else if (len < LW'(N_JOGADAS))   nextState = APERTA_NOVA;
                    else                             nextState = ESPERA_PRONTO;
                end
            end
            APERTA_NOVA:   if (pressDone) nextState = SOLTA_NOVA;
            SOLTA_NOVA:    if (gapDone) nextState = APERTA;
            ESPERA_PRONTO: nextState = ESPERA_PRONTO;
            FIM:           if (iniciar) nextState = LIMPA;
            default:       nextState = OCIOSO;
        endcase
        if (pronto && (state >= ESPERA_EXIBE) && (state <= ESPERA_PRONTO))
            nextState = FIM;
    end

    // Phase timer: restarts on every state change, counts only in timed states
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                             timer <= '0;
        else if (nextState != state || !timed) timer <= '0;
        else                                   timer <= timer + TW'(1);
    end

    // Sequence memory, length and replay index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len <= '0;
            idx <= '0;
            for (int i = 0; i < N_JOGADAS; i++) mem[i] <= 4'b0;
        end else if (nextState == LIMPA) begin
            len <= '0;
            idx <= '0;
            for (int i = 0; i < N_JOGADAS; i++) mem[i] <= 4'b0;
        end else begin
            if (state == ESPERA_EXIBE && nextState == ESPERA_FIM) begin
                mem[0] <= leds;
                len    <= LW'(1);
            end
            if (state == PAUSA && nextState == APERTA) idx <= '0;
            if (state == SOLTA && nextState == APERTA) idx <= idx + AW'(1);
            if (state == SOLTA && nextState == APERTA_NOVA) mem[AW'(len)] <= newMove;
            if (state == SOLTA_NOVA && nextState == APERTA) begin
                len <= len + LW'(1);
                idx <= '0;
            end
        end
    end

    // Moore outputs decoded from registered state
    always_comb begin
        botoes = 4'b0;
        case (state)
            APERTA:      botoes = mem[idx];
            APERTA_NOVA: botoes = mem[AW'(len)];
            default:     botoes = 4'b0;
        endcase
    end

    assign jogando    = (state != OCIOSO) && (state != FIM);
    assign db_tamanho = len;
    assign db_estado  = state;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico with short timings and N_JOGADAS=3.
module tb_jogador_automatico;

    localparam int N  = 3;
    localparam int TP = 4;
    localparam int TG = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, exibe = 1'b0, pronto = 1'b0;
    logic [3:0] leds = 4'b0;
    logic [3:0] botoes;
    logic       jogando;
    logic [1:0] db_tamanho;
    logic [3:0] db_estado;

    int nErr = 0;
    int nChecks = 0;

    jogador_automatico #(.N_JOGADAS(N), .T_PRESS(TP), .T_GAP(TG), .SEED(8'hA5)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .exibe(exibe), .leds(leds),
        .pronto(pronto), .botoes(botoes), .jogando(jogando),
        .db_tamanho(db_tamanho), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Reference LFSR (Fibonacci, taps 8,6,5,4, shifting left); mPrev holds
    // the value present before the most recent edge
    logic [7:0] mL, mPrev;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mL    <= 8'hA5;
            mPrev <= 8'hA5;
        end else begin
            mPrev <= mL;
            mL    <= {mL[6:0], mL[7] ^ mL[5] ^ mL[4] ^ mL[3]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Wait for the next press, check the release gap before it, its value,
    // its state and its width; for a new move the value comes from the model
    task automatic press(input string tag, input logic [3:0] expIn, input bit isNew,
                         output logic [3:0] seen);
        int gap = 0, hi = 0, guard = 0;
        logic [3:0] exp;
        seen = 4'b0;
        while (botoes == 4'b0 && guard < 200) begin
            if (db_estado inside {4'd4, 4'd6, 4'd8}) gap++;
            tick;
            guard++;
        end
        if (guard >= 200) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        exp = isNew ? (4'b0001 << mPrev[1:0]) : expIn;
        chk({tag, "_gap"}, gap, TG);
        chk({tag, "_val"}, botoes, exp);
        chk({tag, "_st"}, db_estado, isNew ? 4'd7 : 4'd5);
        seen = botoes;
        while (botoes == seen && hi < 100) begin
            hi++;
            tick;
        end
        chk({tag, "_width"}, hi, TP);
        chk({tag, "_rel"}, botoes, 4'b0);
    endtask

    task automatic waitBotoes(input string tag);
        int guard = 0;
        while (botoes == 4'b0 && guard < 200) begin
            tick;
            guard++;
        end
        if (guard >= 200) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m0, m1, m2, s;
        int guard;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("rst_botoes", botoes, 0);
        chk("rst_jogando", jogando, 0);
        chk("rst_tam", db_tamanho, 0);
        chk("rst_estado", db_estado, 0);
        reset = 1'b0;

        // Test 1: capture 0100, first round
        iniciar = 1'b1; tick;
        chk("t1_limpa", db_estado, 1);
        chk("t1_jogando", jogando, 1);
        iniciar = 1'b0; tick;
        chk("t1_espera", db_estado, 2);
        exibe = 1'b1; leds = 4'b0100; tick;
        chk("t1_cap_st", db_estado, 3);
        chk("t1_cap_len", db_tamanho, 1);
        repeat (4) tick;
        chk("t1_hold_st", db_estado, 3);
        exibe = 1'b0; leds = 4'b0;
        m0 = 4'b0100;
        press("t1_rep0", m0, 1'b0, s);
        press("t1_new", 4'b0, 1'b1, m1);
        chk("t1_len_pre", db_tamanho, 1);

        // Test 2: round 2 replays mem0, mem1, then a new move
        press("t2_rep0", m0, 1'b0, s);
        chk("t2_len", db_tamanho, 2);
        press("t2_rep1", m1, 1'b0, s);
        press("t2_new", 4'b0, 1'b1, m2);

        // Test 5: full sequence replay, then espera_pronto with no new move
        press("t5_rep0", m0, 1'b0, s);
        chk("t5_len", db_tamanho, 3);
        press("t5_rep1", m1, 1'b0, s);
        press("t5_rep2", m2, 1'b0, s);
        guard = 0;
        while (db_estado != 4'd9 && guard < 20) begin
            tick;
            guard++;
        end
        chk("t5_pronto_st", db_estado, 9);
        repeat (10) tick;
        chk("t5_idle_st", db_estado, 9);
        chk("t5_idle_bot", botoes, 0);
        chk("t5_idle_len", db_tamanho, 3);
        pronto = 1'b1; tick; pronto = 1'b0;
        chk("t5_fim", db_estado, 10);
        chk("t5_fim_jog", jogando, 0);

        // Test 3: non-one-hot leds ignored
        iniciar = 1'b1; tick;
        chk("t3_limpa", db_estado, 1);
        chk("t3_len0", db_tamanho, 0);
        iniciar = 1'b0; tick;
        exibe = 1'b1; leds = 4'b0110; tick; tick;
        chk("t3_0110_st", db_estado, 2);
        chk("t3_0110_len", db_tamanho, 0);
        leds = 4'b0000; tick; tick;
        chk("t3_0000_st", db_estado, 2);
        leds = 4'b0001; tick;
        chk("t3_cap_st", db_estado, 3);
        chk("t3_cap_len", db_tamanho, 1);
        exibe = 1'b0; leds = 4'b0;

        // Test 4: pronto mid-aperta truncates the press
        waitBotoes("t4_wait");
        chk("t4_first", botoes, 4'b0001);
        chk("t4_st", db_estado, 5);
        tick;
        pronto = 1'b1; tick; pronto = 1'b0;
        chk("t4_fim", db_estado, 10);
        chk("t4_bot", botoes, 0);
        chk("t4_jog", jogando, 0);
        iniciar = 1'b1; tick; iniciar = 1'b0;
        chk("t4_limpa", db_estado, 1);
        chk("t4_len0", db_tamanho, 0);

        // Test 6: async reset during aperta_nova
        tick;
        exibe = 1'b1; leds = 4'b1000; tick;
        exibe = 1'b0; leds = 4'b0;
        press("t6_rep0", 4'b1000, 1'b0, s);
        waitBotoes("t6_wait");
        chk("t6_nova_st", db_estado, 7);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_bot", botoes, 0);
        chk("t6_rst_jog", jogando, 0);
        chk("t6_rst_len", db_tamanho, 0);
        chk("t6_rst_st", db_estado, 0);
        tick;
        reset = 1'b0;

        // LFSR restarts from seed: new move tracks the reset reference model
        iniciar = 1'b1; tick; iniciar = 1'b0; tick;
        exibe = 1'b1; leds = 4'b0010; tick;
        exibe = 1'b0; leds = 4'b0;
        press("t6b_rep0", 4'b0010, 1'b0, s);
        press("t6b_new", 4'b0, 1'b1, s);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
